// File: rtl/mac_rr_scheduler.sv
// mac_rr_scheduler: round-robin shared 8-bit MAC (a*b+c) with a one-entry registered result slot
// Optional MAC_SAT_EN: unsigned saturation of the result plus a registered sat_flag output.
module mac_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*DATA_W-1:0] req_c,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
`ifdef MAC_SAT_EN
  output logic                      sat_flag,
`endif
  output logic                      busy
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   g;
  logic              found;
  logic              can_accept;
  logic              accept;
  logic [DATA_W-1:0] a_g, b_g, c_g;
  logic [DATA_W-1:0] res;
`ifdef MAC_SAT_EN
  logic              sat_q, sat_d;
  logic              sat;
  logic [2*DATA_W-1:0] sum;
`endif
  // Winner is the first valid requester at or after ptr, wrapping around.
  always_comb begin
    int idx;
    g = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        g = ID_W'(idx);
        found = 1'b1;
      end
    end
  end
  assign can_accept = (state_q == EMPTY) || rsp_ready;
  assign accept     = found && can_accept && reset;
  assign req_ready  = accept ? (NUM_REQ'(1) << g) : '0;
  assign a_g = req_a[g*DATA_W +: DATA_W];
  assign b_g = req_b[g*DATA_W +: DATA_W];
  assign c_g = req_c[g*DATA_W +: DATA_W];
`ifdef MAC_SAT_EN
  // Full-width sum; clamp to all-ones when the upper half is non-zero.
  always_comb begin
    sum = (2*DATA_W)'(a_g) * (2*DATA_W)'(b_g) + (2*DATA_W)'(c_g);
    sat = |sum[2*DATA_W-1:DATA_W];
    res = sat ? '1 : sum[DATA_W-1:0];
  end
`else
  assign res = a_g * b_g + c_g;
`endif
  // Slot next-state: load on accept, otherwise drain when the consumer takes the result.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
`ifdef MAC_SAT_EN
    sat_d   = sat_q;
`endif
    if (accept) begin
      state_d = FULL;
      data_d  = res;
      id_d    = g;
      ptr_d   = (g == ID_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
`ifdef MAC_SAT_EN
      sat_d   = sat;
`endif
    end else if (rsp_ready) begin
      state_d = EMPTY;
    end
  end
  // Registered slot and round-robin pointer with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
`ifdef MAC_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
`ifdef MAC_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end
  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign busy      = rsp_valid | (|req_valid);
`ifdef MAC_SAT_EN
  assign sat_flag  = sat_q;
`endif
  // A pending request must stay valid until it is accepted.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
    assert property (@(posedge clock) disable iff (!reset)
      req_valid[i] && !req_ready[i] |=> req_valid[i]);
  end
endmodule

// File: tb/tb_mac_rr_scheduler.sv
// tb_mac_rr_scheduler: directed vector table plus hand-written sequences for mac_rr_scheduler
module tb_mac_rr_scheduler;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_a = '0, req_b = '0, req_c = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;
`ifdef MAC_SAT_EN
  logic        sat_flag;
`endif
  int errors = 0;
  int checks = 0;

  mac_rr_scheduler #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
`ifdef MAC_SAT_EN
    .sat_flag(sat_flag),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       rr;
    logic [7:0] a, b, c;
    logic [3:0] ready;
    logic       bsy;
    logic       valid;
    logic [7:0] data;
    logic [1:0] id;
    logic       sat;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic rst, logic [3:0] v, logic rr, logic [7:0] a, logic [7:0] b,
                              logic [7:0] c, logic [3:0] ready, logic bsy, logic valid,
                              logic [7:0] data, logic [1:0] id, logic sat);
    vec_t r;
    r.rst = rst; r.v = v; r.rr = rr; r.a = a; r.b = b; r.c = c;
    r.ready = ready; r.bsy = bsy; r.valid = valid; r.data = data; r.id = id; r.sat = sat;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lane i gets operand a+i so the winner's lane is visible in the result.
  task automatic drive(logic rst, logic [3:0] v, logic rr, logic [7:0] a, logic [7:0] b, logic [7:0] c);
    reset = rst;
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = a + 8'(i);
      req_b[i*8 +: 8] = b;
      req_c[i*8 +: 8] = c;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [1:0] fair_ids [6];
    fair_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    tbl[0]  = mk(0, 4'b1111, 1, 1, 1, 0, 4'b0000, 1, 0, 8'd0, 0, 0);
    tbl[1]  = mk(0, 4'b1111, 1, 1, 1, 0, 4'b0000, 1, 0, 8'd0, 0, 0);
    tbl[2]  = mk(0, 4'b1111, 1, 1, 1, 0, 4'b0000, 1, 0, 8'd0, 0, 0);
    tbl[3]  = mk(1, 4'b1111, 1, 1, 2, 3, 4'b0001, 1, 1, 8'd5, 0, 0);
    tbl[4]  = mk(1, 4'b1110, 1, 1, 2, 3, 4'b0010, 1, 1, 8'd7, 1, 0);
    tbl[5]  = mk(1, 4'b1100, 1, 1, 2, 3, 4'b0100, 1, 1, 8'd9, 2, 0);
    tbl[6]  = mk(1, 4'b1000, 1, 1, 2, 3, 4'b1000, 1, 1, 8'd11, 3, 0);
    tbl[7]  = mk(1, 4'b0000, 1, 1, 2, 3, 4'b0000, 1, 0, 8'd11, 3, 0);
    tbl[8]  = mk(1, 4'b0000, 0, 1, 2, 3, 4'b0000, 0, 0, 8'd11, 3, 0);
    tbl[9]  = mk(1, 4'b0100, 1, 5, 3, 1, 4'b0100, 1, 1, 8'd22, 2, 0);
    tbl[10] = mk(1, 4'b0010, 0, 5, 3, 1, 4'b0000, 1, 1, 8'd22, 2, 0);
    tbl[11] = mk(1, 4'b0010, 0, 5, 3, 1, 4'b0000, 1, 1, 8'd22, 2, 0);
    tbl[12] = mk(1, 4'b0010, 1, 5, 3, 1, 4'b0010, 1, 1, 8'd19, 1, 0);
    tbl[13] = mk(1, 4'b0011, 1, 5, 3, 1, 4'b0001, 1, 1, 8'd16, 0, 0);
    tbl[14] = mk(1, 4'b0010, 1, 5, 3, 1, 4'b0010, 1, 1, 8'd19, 1, 0);
`ifdef MAC_SAT_EN
    tbl[15] = mk(1, 4'b0001, 1, 255, 255, 255, 4'b0001, 1, 1, 8'hFF, 0, 1);
`else
    tbl[15] = mk(1, 4'b0001, 1, 255, 255, 255, 4'b0001, 1, 1, 8'h00, 0, 0);
`endif
    tbl[16] = mk(1, 4'b0001, 1, 15, 15, 30, 4'b0001, 1, 1, 8'hFF, 0, 0);
    tbl[17] = mk(0, 4'b0000, 0, 1, 2, 3, 4'b0000, 1, 0, 8'd0, 0, 0);
    tbl[18] = mk(1, 4'b1111, 1, 1, 2, 3, 4'b0001, 1, 1, 8'd5, 0, 0);

    drive(0, 4'b0000, 0, 0, 0, 0);
    tick();
    for (int n = 0; n < 19; n++) begin
      drive(tbl[n].rst, tbl[n].v, tbl[n].rr, tbl[n].a, tbl[n].b, tbl[n].c);
      @(negedge clock);
      chk($sformatf("row%0d req_ready", n), 32'(req_ready), 32'(tbl[n].ready));
      chk($sformatf("row%0d busy", n), 32'(busy), 32'(tbl[n].bsy));
      tick();
      chk($sformatf("row%0d rsp_valid", n), 32'(rsp_valid), 32'(tbl[n].valid));
      chk($sformatf("row%0d rsp_data", n), 32'(rsp_data), 32'(tbl[n].data));
      chk($sformatf("row%0d rsp_id", n), 32'(rsp_id), 32'(tbl[n].id));
`ifdef MAC_SAT_EN
      chk($sformatf("row%0d sat_flag", n), 32'(sat_flag), 32'(tbl[n].sat));
`endif
    end

    // Single op from req1 with only lane 1 carrying 3*4+5.
    drive(0, 4'b0000, 1, 0, 0, 0);
    tick();
    reset = 1'b1;
    req_a = 32'h09_09_03_09;
    req_b = 32'h07_07_04_07;
    req_c = 32'h01_01_05_01;
    req_valid = 4'b0010;
    @(negedge clock);
    chk("single req_ready", 32'(req_ready), 32'h2);
    tick();
    chk("single rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single rsp_data", 32'(rsp_data), 32'd17);
    chk("single rsp_id", 32'(rsp_id), 32'h1);

    // Fairness: all requesters held high, one result every cycle in rotating order.
    drive(0, 4'b1111, 1, 1, 1, 1);
    tick();
    reset = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk($sformatf("fair%0d rsp_valid", n), 32'(rsp_valid), 32'h1);
      chk($sformatf("fair%0d rsp_id", n), 32'(rsp_id), 32'(fair_ids[n]));
    end

    // Reset mid-op: hold a result from req3 under backpressure, then reset for one cycle.
    drive(0, 4'b1111, 1, 1, 1, 1);
    tick();
    reset = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    chk("midrst held id", 32'(rsp_id), 32'h3);
    rsp_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clock);
      chk($sformatf("bp%0d req_ready", n), 32'(req_ready), 32'h0);
      tick();
      chk($sformatf("bp%0d rsp_id", n), 32'(rsp_id), 32'h3);
    end
    reset = 1'b0;
    @(negedge clock);
    chk("midrst ready gated", 32'(req_ready), 32'h0);
    tick();
    chk("midrst rsp_valid", 32'(rsp_valid), 32'h0);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst first ready", 32'(req_ready), 32'h1);
    tick();
    chk("midrst first id", 32'(rsp_id), 32'h0);
    chk("midrst first valid", 32'(rsp_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
